// File: rtl/note_highway.sv
// Five-lane falling-note highway: age-ordered note ring, per-frame advance, strum judging, score/streak.
// Optional NOTE_MULTIPLIER_EN: hit score grows with streak (x1..x4); otherwise each hit adds 1.
module note_highway #(
    parameter int SLOTS   = 8,
    parameter int Y_W     = 10,
    parameter int SPEED   = 4,
    parameter int SPAWN_Y = 0,
    parameter int HIT_LO  = 400,
    parameter int HIT_HI  = 440,
    parameter int SCORE_W = 16,
    localparam int IW     = $clog2(SLOTS)
) (
    input  logic               Clk,
    input  logic               RESET_N,
    input  logic               spawn_tick,
    input  logic               g_activate,
    input  logic               r_activate,
    input  logic               y_activate,
    input  logic               b_activate,
    input  logic               o_activate,
    input  logic               frame_tick,
    input  logic               strum,
    input  logic [4:0]         fret,
    input  logic [IW-1:0]      draw_idx,
    output logic               draw_valid,
    output logic [4:0]         draw_lane,
    output logic [Y_W-1:0]     draw_y,
    output logic [IW:0]        count,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         streak,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               overflow_pulse
);

    localparam logic [Y_W:0]   SPEED_C   = (Y_W+1)'(SPEED);
    localparam logic [Y_W:0]   HIT_LO_C  = (Y_W+1)'(HIT_LO);
    localparam logic [Y_W:0]   HIT_HI_C  = (Y_W+1)'(HIT_HI);
    localparam logic [Y_W-1:0] SPAWN_Y_C = Y_W'(SPAWN_Y);
    localparam logic [Y_W-1:0] Y_MAX     = {Y_W{1'b1}};
    localparam logic [IW:0]    SLOTS_C   = (IW+1)'(SLOTS);

    logic [4:0]         lane_q [SLOTS];
    logic [4:0]         lane_d [SLOTS];
    logic [Y_W-1:0]     y_q    [SLOTS];
    logic [Y_W-1:0]     y_d    [SLOTS];
    logic [SLOTS-1:0]   valid_q, valid_d;
    logic [IW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [IW:0]        count_q, count_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         streak_q, streak_d;
    logic               hit_q, hit_d, miss_q, miss_d, ovf_q, ovf_d;

    logic [4:0]         act_s, spawn_lane_s, head_lane_s;
    logic [Y_W-1:0]     head_y_s;
    logic               head_valid_s, full_s, in_window_s;
    logic               hit_s, expire_s, miss_s, pop_s, spawn_any_s, accept_s, ovf_s;
    logic [2:0]         inc_s;
    logic [SCORE_W:0]   score_sum_s;
    logic [IW-1:0]      draw_slot_s;

    function automatic logic [4:0] lowest_set(input logic [4:0] v);
        return v & (~v + 5'd1);
    endfunction

    function automatic logic [Y_W-1:0] sat_advance(input logic [Y_W-1:0] y);
        logic [Y_W:0] s;
        s = {1'b0, y} + SPEED_C;
        return s[Y_W] ? Y_MAX : s[Y_W-1:0];
    endfunction

`ifdef NOTE_MULTIPLIER_EN
    function automatic logic [2:0] mult_inc(input logic [7:0] s);
        if (s >= 8'd24) begin
            return 3'd4;
        end else begin
            return {1'b0, s[4:3]} + 3'd1;
        end
    endfunction
`endif

    assign act_s        = {o_activate, b_activate, y_activate, r_activate, g_activate};
    assign spawn_lane_s = lowest_set(act_s);
    assign head_lane_s  = lane_q[head_q];
    assign head_y_s     = y_q[head_q];
    assign head_valid_s = (count_q != {(IW+1){1'b0}});
    assign full_s       = (count_q == SLOTS_C);
    assign in_window_s  = ({1'b0, head_y_s} >= HIT_LO_C) && ({1'b0, head_y_s} <= HIT_HI_C);

    // Strum is judged first; a strum pop defers expiry of the new head to a later frame.
    assign hit_s       = strum && head_valid_s && in_window_s && (fret == head_lane_s);
    assign expire_s    = frame_tick && head_valid_s && !hit_s && (({1'b0, head_y_s} + SPEED_C) > HIT_HI_C);
    assign miss_s      = (strum && !hit_s) || expire_s;
    assign pop_s       = hit_s || expire_s;
    assign spawn_any_s = spawn_tick && (act_s != 5'd0);
    assign accept_s    = spawn_any_s && (!full_s || pop_s);
    assign ovf_s       = spawn_any_s && full_s && !pop_s;

`ifdef NOTE_MULTIPLIER_EN
    assign inc_s = mult_inc(streak_q);
`else
    assign inc_s = 3'd1;
`endif
    assign score_sum_s = {1'b0, score_q} + (SCORE_W+1)'(inc_s);

    // Next-state for ring, score, streak and event strobes.
    always_comb begin
        lane_d   = lane_q;
        y_d      = y_q;
        valid_d  = valid_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        score_d  = score_q;
        streak_d = streak_q;
        hit_d    = hit_s;
        miss_d   = miss_s;
        ovf_d    = ovf_s;

        for (int i = 0; i < SLOTS; i++) begin
            if (frame_tick && valid_q[i]) begin
                y_d[i] = sat_advance(y_q[i]);
            end else begin
                y_d[i] = y_q[i];
            end
        end

        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IW'(1'b1);
        end else begin
            head_d = head_q;
        end

        // Spawn write lands after the pop so a full ring can recycle the freed head slot.
        if (accept_s) begin
            lane_d[tail_q]  = spawn_lane_s;
            y_d[tail_q]     = SPAWN_Y_C;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + IW'(1'b1);
        end else begin
            tail_d = tail_q;
        end

        if (accept_s && !pop_s) begin
            count_d = count_q + (IW+1)'(1'b1);
        end else if (pop_s && !accept_s) begin
            count_d = count_q - (IW+1)'(1'b1);
        end else begin
            count_d = count_q;
        end

        if (hit_s) begin
            streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
            score_d  = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
        end else if (miss_s) begin
            streak_d = 8'd0;
            score_d  = score_q;
        end else begin
            streak_d = streak_q;
            score_d  = score_q;
        end
    end

    // State registers.
    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SLOTS; i++) begin
                lane_q[i] <= 5'd0;
                y_q[i]    <= {Y_W{1'b0}};
            end
            valid_q  <= {SLOTS{1'b0}};
            head_q   <= {IW{1'b0}};
            tail_q   <= {IW{1'b0}};
            count_q  <= {(IW+1){1'b0}};
            score_q  <= {SCORE_W{1'b0}};
            streak_q <= 8'd0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            score_q  <= score_d;
            streak_q <= streak_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            ovf_q    <= ovf_d;
        end
    end

    assign draw_slot_s    = head_q + draw_idx;
    assign draw_valid     = ({1'b0, draw_idx} < count_q);
    assign draw_lane      = draw_valid ? lane_q[draw_slot_s] : 5'd0;
    assign draw_y         = draw_valid ? y_q[draw_slot_s] : {Y_W{1'b0}};
    assign count          = count_q;
    assign score          = score_q;
    assign streak         = streak_q;
    assign hit_pulse      = hit_q;
    assign miss_pulse     = miss_q;
    assign overflow_pulse = ovf_q;

endmodule

// File: tb/tb_note_highway.sv
// Scoreboard bench for note_highway: a queue-based note model predicts every cycle's outputs.
module tb_note_highway;

    logic       Clk = 1'b0;
    logic       RESET_N;
    logic       spawn_tick, g_activate, r_activate, y_activate, b_activate, o_activate;
    logic       frame_tick, strum;
    logic [4:0] fret;
    logic [2:0] draw_idx;
    logic       draw_valid;
    logic [4:0] draw_lane;
    logic [9:0] draw_y;
    logic [3:0] count;
    logic [15:0] score;
    logic [7:0] streak;
    logic       hit_pulse, miss_pulse, overflow_pulse;

    always #5 Clk = ~Clk;

    note_highway dut (
        .Clk(Clk), .RESET_N(RESET_N), .spawn_tick(spawn_tick),
        .g_activate(g_activate), .r_activate(r_activate), .y_activate(y_activate),
        .b_activate(b_activate), .o_activate(o_activate),
        .frame_tick(frame_tick), .strum(strum), .fret(fret), .draw_idx(draw_idx),
        .draw_valid(draw_valid), .draw_lane(draw_lane), .draw_y(draw_y),
        .count(count), .score(score), .streak(streak),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .overflow_pulse(overflow_pulse)
    );

    typedef struct {
        bit hit, miss, ovf, dv;
        int cnt, score, streak, dl, dy;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] q_lane[$];
    int         q_y[$];
    int         m_score, m_streak;
    int         total = 0;
    int         bad = 0;

`ifdef NOTE_MULTIPLIER_EN
    localparam int MULT_SCORE = 12;
`else
    localparam int MULT_SCORE = 10;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: model predicts, pushes expectation, then pops and compares after the edge.
    task automatic step(input bit sp, input logic [4:0] act, input bit fr, input bit st, input logic [4:0] fv);
        exp_t e;
        bit hit, expd, pop, full;
        logic [4:0] ln;
        int inc, idx;
        draw_idx   = 3'($urandom_range(0, 7));
        spawn_tick = sp;
        {o_activate, b_activate, y_activate, r_activate, g_activate} = act;
        frame_tick = fr;
        strum      = st;
        fret       = fv;

        hit  = st && q_y.size() > 0 && q_y[0] >= 400 && q_y[0] <= 440 && fv == q_lane[0];
        expd = fr && q_y.size() > 0 && !hit && (q_y[0] + 4 > 440);
        pop  = hit || expd;
        full = (q_y.size() == 8);
        e.hit  = hit;
        e.miss = (st && !hit) || expd;
        e.ovf  = 1'b0;
        if (fr) foreach (q_y[i]) q_y[i] = (q_y[i] + 4 > 1023) ? 1023 : q_y[i] + 4;
        if (pop) begin
            void'(q_y.pop_front());
            void'(q_lane.pop_front());
        end
        ln = 5'd0;
        for (int k = 4; k >= 0; k--) if (act[k]) ln = 5'd1 << k;
        if (sp && ln != 5'd0) begin
            if (full && !pop) e.ovf = 1'b1;
            else begin
                q_lane.push_back(ln);
                q_y.push_back(0);
            end
        end
        if (hit) begin
`ifdef NOTE_MULTIPLIER_EN
            inc = (m_streak >= 24) ? 4 : 1 + m_streak / 8;
`else
            inc = 1;
`endif
            m_score  = (m_score + inc > 65535) ? 65535 : m_score + inc;
            m_streak = (m_streak == 255) ? 255 : m_streak + 1;
        end else if (e.miss) m_streak = 0;
        e.cnt = q_y.size(); e.score = m_score; e.streak = m_streak;
        idx = int'(draw_idx);
        e.dv = idx < q_y.size();
        e.dl = e.dv ? int'(q_lane[idx]) : 0;
        e.dy = e.dv ? q_y[idx] : 0;
        sb.push_back(e);

        @(posedge Clk);
        #1;
        spawn_tick = 1'b0;
        {o_activate, b_activate, y_activate, r_activate, g_activate} = 5'd0;
        frame_tick = 1'b0; strum = 1'b0; fret = 5'd0;
        e = sb.pop_front();
        chk("hit_pulse", int'(hit_pulse), int'(e.hit));
        chk("miss_pulse", int'(miss_pulse), int'(e.miss));
        chk("overflow_pulse", int'(overflow_pulse), int'(e.ovf));
        chk("count", int'(count), e.cnt);
        chk("score", int'(score), e.score);
        chk("streak", int'(streak), e.streak);
        chk("draw_valid", int'(draw_valid), int'(e.dv));
        chk("draw_lane", int'(draw_lane), e.dl);
        chk("draw_y", int'(draw_y), e.dy);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b1, 1'b0, 5'd0);
    endtask

    task automatic check_reset_state(input string tag);
        draw_idx = 3'd0;
        #1;
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_streak"}, int'(streak), 0);
        chk({tag, "_draw_valid"}, int'(draw_valid), 0);
        chk({tag, "_draw_lane"}, int'(draw_lane), 0);
        chk({tag, "_draw_y"}, int'(draw_y), 0);
        chk({tag, "_pulses"}, int'({hit_pulse, miss_pulse, overflow_pulse}), 0);
    endtask

    initial begin
        RESET_N = 1'b1;
        spawn_tick = 1'b0; frame_tick = 1'b0; strum = 1'b0; fret = 5'd0; draw_idx = 3'd0;
        {o_activate, b_activate, y_activate, r_activate, g_activate} = 5'd0;
        m_score = 0; m_streak = 0;
        #2 RESET_N = 1'b0;
        #10;
        check_reset_state("rst0");
        @(negedge Clk) RESET_N = 1'b1;
        @(posedge Clk); #1;

        // Priority green: g+b spawns green; hit at y=400.
        step(1'b1, 5'b01001, 1'b0, 1'b0, 5'd0);
        frames(100);
        step(1'b0, 5'd0, 1'b0, 1'b1, 5'b00001);
        chk("first_hit_score", int'(score), 1);

        // Extra fret is a miss; note later expires past the window.
        step(1'b1, 5'b00010, 1'b0, 1'b0, 5'd0);
        frames(102);
        step(1'b0, 5'd0, 1'b0, 1'b1, 5'b00011);
        frames(9);
        chk("expired_count", int'(count), 0);

        // Strum and frame together at y=440: hit, not expiry.
        step(1'b1, 5'b00100, 1'b0, 1'b0, 5'd0);
        frames(110);
        step(1'b0, 5'd0, 1'b1, 1'b1, 5'b00100);

        // Fill ring, overflow on the 9th spawn, spawn accepted alongside a hit.
        for (int i = 0; i < 9; i++) step(1'b1, (5'b00001 << (i % 5)) | 5'b10000, 1'b0, 1'b0, 5'd0);
        frames(100);
        step(1'b1, 5'b00100, 1'b0, 1'b1, q_lane[0]);
        chk("full_spawn_count", int'(count), 8);
        for (int i = 0; i < 7; i++) step(1'b0, 5'd0, 1'b0, 1'b1, q_lane[0]);
        step(1'b1, 5'b00010, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'b01000, 1'b0, 1'b0, 5'd0);

        // Asynchronous reset mid-run with notes held.
        #2 RESET_N = 1'b0;
        q_y.delete(); q_lane.delete(); m_score = 0; m_streak = 0;
        check_reset_state("rst_mid");
        @(negedge Clk) RESET_N = 1'b1;
        @(posedge Clk); #1;

        // Ten consecutive hits from a fresh score.
        for (int i = 0; i < 8; i++) step(1'b1, 5'b00001, 1'b0, 1'b0, 5'd0);
        frames(100);
        for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 1'b0, 1'b1, 5'b00001);
        for (int i = 0; i < 2; i++) step(1'b1, 5'b00001, 1'b0, 1'b0, 5'd0);
        frames(100);
        for (int i = 0; i < 2; i++) step(1'b0, 5'd0, 1'b0, 1'b1, 5'b00001);
        chk("ten_hit_score", int'(score), MULT_SCORE);
        chk("ten_hit_streak", int'(streak), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
